// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: two-requester round-robin arbiter feeding a 16x-oversampled UART transmitter
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   s_tick              one-cycle 16x-oversample strobe
//   reqN_valid/data     requester N offers a byte
//   reqN_ready          requester N byte accepted this cycle (IDLE only)
//   tx                  registered serial line, idle high
//   tx_busy             frame in progress (START/DATA/STOP)
//   grant_id            requester owning the current or last frame
//   tx_done_tick        one-cycle pulse at the end of the stop bit
`timescale 1ns/1ps
module uart_tx_scheduler #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            s_tick,
  input  logic            req0_valid,
  input  logic [DBIT-1:0] req0_data,
  output logic            req0_ready,
  input  logic            req1_valid,
  input  logic [DBIT-1:0] req1_data,
  output logic            req1_ready,
  output logic            tx,
  output logic            tx_busy,
  output logic            grant_id,
  output logic            tx_done_tick
);
  // the tick counter must also reach SB_TICK-1 during the stop bit
  localparam int TW = SB_TICK > 16 ? $clog2(SB_TICK) : 4;
  localparam int BW = DBIT > 1 ? $clog2(DBIT) : 1;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t          state_q;
  logic [TW-1:0]   tick_q;
  logic [BW-1:0]   bit_q;
  logic [DBIT-1:0] shift_q, shift_d;
  logic            rr_q, tx_q, busy_q, done_q, gid_q;
  logic            any_v, gnt1_d, tick_last;
  logic [TW-1:0]   tick_max;
  // rr_q=0 favours requester 0 on contention; a lone valid requester always wins
  always_comb begin
    any_v     = req0_valid | req1_valid;
    gnt1_d    = req1_valid & (~req0_valid | rr_q);
    shift_d   = shift_q >> 1;
    tick_max  = (state_q == STOP) ? TW'(SB_TICK - 1) : TW'(15);
    tick_last = s_tick & (tick_q == tick_max);
  end
  // readies are qualified with reset_n so a held valid is never acknowledged while in reset
  assign req0_ready   = reset_n & (state_q == IDLE) & any_v & ~gnt1_d;
  assign req1_ready   = reset_n & (state_q == IDLE) & gnt1_d;
  assign tx           = tx_q;
  assign tx_busy      = busy_q;
  assign grant_id     = gid_q;
  assign tx_done_tick = done_q;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      rr_q    <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      gid_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state_q != IDLE && s_tick) tick_q <= tick_last ? '0 : tick_q + 1'b1;
      case (state_q)
        IDLE: if (any_v) begin
          state_q <= START;
          tx_q    <= 1'b0;
          busy_q  <= 1'b1;
          gid_q   <= gnt1_d;
          rr_q    <= ~gnt1_d;
          shift_q <= gnt1_d ? req1_data : req0_data;
          tick_q  <= '0;
          bit_q   <= '0;
        end
        START: if (tick_last) begin
          state_q <= DATA;
          tx_q    <= shift_q[0];
        end
        DATA: if (tick_last) begin
          shift_q <= shift_d;
          if (bit_q == BW'(DBIT - 1)) begin
            state_q <= STOP;
            tx_q    <= 1'b1;
          end else begin
            bit_q <= bit_q + 1'b1;
            tx_q  <= shift_d[0];
          end
        end
        STOP: if (tick_last) begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_scheduler.sv
// tb_uart_tx_scheduler: directed, table-driven bench for uart_tx_scheduler
`timescale 1ns/1ps
module tb_uart_tx_scheduler;
  localparam int LIM = 20000;
  logic clk = 1'b0, reset_n = 1'b0, s_tick = 1'b0, tick_en = 1'b1;
  logic r0v = 1'b0, r1v = 1'b0;
  logic [7:0] r0d = '0, r1d = '0;
  logic req0_ready, req1_ready, tx, tx_busy, grant_id, tx_done_tick;
  logic q0v = 1'b0, q1v = 1'b0;
  logic [6:0] q0d = '0, q1d = '0;
  logic rdy7_0, rdy7_1, tx7, busy7, gid7, done7;
  int errors = 0, checks = 0, ndone = 0, tcnt = 0;
  uart_tx_scheduler dut (
    .clk(clk), .reset_n(reset_n), .s_tick(s_tick),
    .req0_valid(r0v), .req0_data(r0d), .req0_ready(req0_ready),
    .req1_valid(r1v), .req1_data(r1d), .req1_ready(req1_ready),
    .tx(tx), .tx_busy(tx_busy), .grant_id(grant_id), .tx_done_tick(tx_done_tick)
  );
  uart_tx_scheduler #(.DBIT(7), .SB_TICK(32)) dut7 (
    .clk(clk), .reset_n(reset_n), .s_tick(s_tick),
    .req0_valid(q0v), .req0_data(q0d), .req0_ready(rdy7_0),
    .req1_valid(q1v), .req1_data(q1d), .req1_ready(rdy7_1),
    .tx(tx7), .tx_busy(busy7), .grant_id(gid7), .tx_done_tick(done7)
  );
  always #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    #1;
    tcnt = (tcnt == 3) ? 0 : tcnt + 1;
    s_tick = tick_en && tcnt == 0;
  end
  always @(negedge clk) if (tx_done_tick) ndone <= ndone + 1;
  typedef struct {
    logic v0, v1;
    logic [7:0] d0, d1;
    logic gid;
    logic [7:0] exp;
  } vec_t;
  vec_t tv [8];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic logic txs(input bit s);
    return s ? tx7 : tx;
  endfunction
  function automatic logic dn(input bit s);
    return s ? done7 : tx_done_tick;
  endfunction
  task automatic wait_ready(input bit s, output logic ok);
    ok = 1'b0;
    for (int t = 0; t < 100 && !ok; t++) begin
      @(negedge clk);
      ok = s ? (rdy7_0 | rdy7_1) : (req0_ready | req1_ready);
    end
  endtask
  // decodes one frame by counting s_tick pulses, samples mid-bit, returns at the done negedge
  task automatic capture(input bit s, input int d, output logic [7:0] data, output logic fok, output int extra);
    logic [9:0] bits;
    int n, k, t;
    bit fin;
    bits = '0; n = 0; k = 0; t = 0; fin = 0; extra = 0; data = '0;
    @(negedge clk);
    while (txs(s) !== 1'b0 && t < LIM) begin
      @(negedge clk);
      t++;
    end
    while (!fin && t < LIM) begin
      if (k > d + 1 && dn(s)) fin = 1;
      else begin
        if (s_tick) begin
          n++;
          if (k <= d + 1 && n == 8 + 16 * k) begin
            bits[k] = txs(s);
            k++;
          end else if (k > d + 1) extra++;
        end
        @(negedge clk);
        t++;
      end
    end
    for (int i = 0; i < d; i++) data[i] = bits[i+1];
    fok = fin && bits[0] == 1'b0 && bits[d+1] == 1'b1;
  endtask
  task automatic frame0(input string name, input logic [7:0] exp);
    logic [7:0] b;
    logic fok;
    int ex;
    capture(0, 8, b, fok, ex);
    chk({name, "_byte"}, b, exp);
    chk({name, "_frame"}, fok, 1);
    chk({name, "_stop_len"}, ex, 8);
  endtask
  initial begin
    logic ok, fok, ref_tx;
    logic [7:0] b;
    int ex, len, nd, chg;
    tv[0] = '{1, 0, 8'hA5, 8'h00, 0, 8'hA5};
    tv[1] = '{0, 1, 8'h00, 8'h3C, 1, 8'h3C};
    tv[2] = '{1, 1, 8'h11, 8'h22, 0, 8'h11};
    tv[3] = '{1, 1, 8'h55, 8'hAA, 1, 8'hAA};
    tv[4] = '{0, 1, 8'h00, 8'h80, 1, 8'h80};
    tv[5] = '{1, 1, 8'h01, 8'hFE, 0, 8'h01};
    tv[6] = '{1, 0, 8'hFF, 8'h00, 0, 8'hFF};
    tv[7] = '{1, 1, 8'h00, 8'h7E, 1, 8'h7E};
    repeat (3) @(negedge clk);
    chk("rst_tx", tx, 1);
    chk("rst_busy", tx_busy, 0);
    chk("rst_done", tx_done_tick, 0);
    chk("rst_gid", grant_id, 0);
    chk("rst_ready", {req0_ready, req1_ready}, 0);
    chk("rst_tx7", tx7, 1);
    @(posedge clk);
    #1 reset_n = 1'b1;
    // single byte 0xA5 with bit-length measurement
    repeat (5) @(posedge clk);
    #1 r0v = 1'b1; r0d = 8'hA5;
    nd = ndone;
    wait_ready(0, ok);
    chk("sb_ready_seen", ok, 1);
    chk("sb_ready", {req0_ready, req1_ready}, 2'b10);
    @(posedge clk);
    #1 r0v = 1'b0;
    chk("sb_gid", grant_id, 0);
    chk("sb_busy", tx_busy, 1);
    fork
      frame0("sb", 8'hA5);
      begin
        len = 0;
        for (int t = 0; t < 2000 && tx !== 1'b0; t++) @(negedge clk);
        for (int t = 0; t < 2000 && tx !== 1'b1; t++) @(negedge clk);
        while (tx === 1'b1 && len < 1000) begin
          len++;
          @(negedge clk);
        end
      end
    join
    chk("sb_bit_len", len, 64);
    chk("sb_busy_end", tx_busy, 0);
    repeat (200) @(negedge clk);
    chk("sb_done_count", ndone - nd, 1);
    // contention from reset: req0, then req1 back-to-back, then req0 again
    reset_n = 1'b0;
    r0v = 1'b1; r0d = 8'h11; r1v = 1'b1; r1d = 8'h22;
    repeat (2) @(negedge clk);
    chk("ct_rst_ready", {req0_ready, req1_ready}, 0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    wait_ready(0, ok);
    chk("ct_first_ready", {req0_ready, req1_ready}, 2'b10);
    @(posedge clk);
    #1 r0v = 1'b0;
    chk("ct_gid0", grant_id, 0);
    frame0("ct1", 8'h11);
    chk("ct_b2b_ready", {req0_ready, req1_ready}, 2'b01);
    @(posedge clk);
    #1 r0v = 1'b1; r0d = 8'h33; r1v = 1'b1; r1d = 8'h44;
    chk("ct_gid1", grant_id, 1);
    frame0("ct2", 8'h22);
    chk("ct_third_ready", {req0_ready, req1_ready}, 2'b10);
    @(posedge clk);
    #1 r0v = 1'b0; r1v = 1'b0;
    chk("ct_gid2", grant_id, 0);
    frame0("ct3", 8'h33);
    // table of single frames starting from a fresh round-robin pointer
    @(posedge clk);
    #1 reset_n = 1'b0;
    @(posedge clk);
    #1 reset_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1 r0v = tv[i].v0; r0d = tv[i].d0; r1v = tv[i].v1; r1d = tv[i].d1;
      wait_ready(0, ok);
      chk("tbl_ready_seen", ok, 1);
      chk("tbl_ready", {req0_ready, req1_ready}, {~tv[i].gid, tv[i].gid});
      @(posedge clk);
      #1 r0v = 1'b0; r1v = 1'b0;
      chk("tbl_gid", grant_id, tv[i].gid);
      chk("tbl_busy", tx_busy, 1);
      frame0("tbl", tv[i].exp);
      chk("tbl_busy_end", tx_busy, 0);
    end
    // tick gating: freeze for 1000 clk mid-DATA
    @(posedge clk);
    #1 r0v = 1'b1; r0d = 8'h96;
    wait_ready(0, ok);
    @(posedge clk);
    #1 r0v = 1'b0;
    nd = ndone;
    chg = 0;
    fork
      frame0("gate", 8'h96);
      begin
        repeat (200) @(negedge clk);
        tick_en = 1'b0;
        repeat (3) @(negedge clk);
        ref_tx = tx;
        repeat (1000) begin
          @(negedge clk);
          if (tx !== ref_tx || tx_busy !== 1'b1 || ndone != nd) chg++;
        end
        tick_en = 1'b1;
      end
    join
    chk("gate_frozen", chg, 0);
    // data stability after acceptance
    @(posedge clk);
    #1 r0v = 1'b1; r0d = 8'h3C;
    wait_ready(0, ok);
    @(posedge clk);
    #1 r0v = 1'b0; r0d = 8'hFF;
    frame0("stab", 8'h3C);
    // mid-frame reset during bit 3 of 0x52
    @(posedge clk);
    #1 r0v = 1'b1; r0d = 8'h52;
    wait_ready(0, ok);
    @(posedge clk);
    #1 r0v = 1'b0;
    len = 0;
    for (int t = 0; t < 2000 && tx !== 1'b0; t++) @(negedge clk);
    for (int t = 0; t < 4000 && len < 72; t++) begin
      @(negedge clk);
      if (s_tick) len++;
    end
    chk("mr_pre_tx", tx, 0);
    nd = ndone;
    reset_n = 1'b0;
    #1;
    chk("mr_async_tx", tx, 1);
    chk("mr_async_busy", tx_busy, 0);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (300) @(negedge clk);
    chk("mr_no_done", ndone - nd, 0);
    @(posedge clk);
    #1 r1v = 1'b1; r1d = 8'hC3;
    wait_ready(0, ok);
    chk("mr_ready", {req0_ready, req1_ready}, 2'b01);
    @(posedge clk);
    #1 r1v = 1'b0;
    chk("mr_gid", grant_id, 1);
    frame0("mr_next", 8'hC3);
    // DBIT=7, SB_TICK=32 instance
    @(posedge clk);
    #1 q0v = 1'b1; q0d = 7'h5B;
    wait_ready(1, ok);
    chk("p7_ready", {rdy7_0, rdy7_1}, 2'b10);
    @(posedge clk);
    #1 q0v = 1'b0;
    chk("p7_busy", busy7, 1);
    capture(1, 7, b, fok, ex);
    chk("p7_byte", b, 8'h5B);
    chk("p7_frame", fok, 1);
    chk("p7_stop_len", ex, 24);
    chk("p7_gid", gid7, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
